// File: rtl/execute_unit_p.sv
// Registered execute stage: forwarding operand muxes, single-cycle ALU,
// architectural {C,N,Z} flag register with restore path, and EX/MEM register.
module execute_unit_p #(
   parameter int WIDTH   = 16,
   parameter int RADDR_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic               stall,
   input  logic               flush,
   input  logic [WIDTH-1:0]   data1_val,
   input  logic [WIDTH-1:0]   data2_val,
   input  logic [WIDTH-1:0]   imm_val,
   input  logic [1:0]         fwd_a,
   input  logic [1:0]         fwd_b,
   input  logic               use_imm,
   input  logic [2:0]         alu_op,
   input  logic               flag_we,
   input  logic               flag_src,
   input  logic [2:0]         flags_restore,
   input  logic [RADDR_W-1:0] rdst_in,
   input  logic               reg_write_in,
   input  logic [WIDTH-1:0]   wb_data,
   output logic               ex_valid,
   output logic [WIDTH-1:0]   ex_result,
   output logic [RADDR_W-1:0] ex_rdst,
   output logic               ex_reg_write,
   output logic [2:0]         flags
);

   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [2:0] {
      OP_PASS = 3'd0,
      OP_ADD  = 3'd1,
      OP_SUB  = 3'd2,
      OP_AND  = 3'd3,
      OP_OR   = 3'd4,
      OP_NOT  = 3'd5,
      OP_SHL  = 3'd6,
      OP_SHR  = 3'd7
   } alu_op_e;

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH:0]   wide;
   logic [SHW-1:0]   sh;
   logic             c_new;
   logic             alu_flag_upd;

   always_comb begin
      op_a = data1_val;
      case (fwd_a)
         2'd0: op_a = data1_val;
         2'd1: op_a = ex_result;
         2'd2: op_a = wb_data;
         2'd3: op_a = data2_val;
      endcase
   end

   always_comb begin
      op_b = data2_val;
      if (use_imm) begin
         op_b = imm_val;
      end else begin
         case (fwd_b)
            2'd0: op_b = data2_val;
            2'd1: op_b = ex_result;
            2'd2: op_b = wb_data;
            2'd3: op_b = {{(WIDTH-1){1'b0}}, 1'b1};
         endcase
      end
   end

   assign sh = op_b[SHW-1:0];

   // The extra bit of 'wide' carries C: carry/borrow for ADD/SUB, the last bit
   // shifted out for SHL (top) and SHR (bottom, A pre-extended by one zero).
   always_comb begin
      alu_res = '0;
      wide    = '0;
      c_new   = flags[2];
      case (alu_op_e'(alu_op))
         OP_PASS: alu_res = op_a;
         OP_ADD: begin
            wide    = {1'b0, op_a} + {1'b0, op_b};
            alu_res = wide[WIDTH-1:0];
            c_new   = wide[WIDTH];
         end
         OP_SUB: begin
            wide    = {1'b0, op_a} - {1'b0, op_b};
            alu_res = wide[WIDTH-1:0];
            c_new   = wide[WIDTH];
         end
         OP_AND: alu_res = op_a & op_b;
         OP_OR:  alu_res = op_a | op_b;
         OP_NOT: alu_res = ~op_a;
         OP_SHL: begin
            wide    = {1'b0, op_a} << sh;
            alu_res = wide[WIDTH-1:0];
            if (sh != '0) c_new = wide[WIDTH];
         end
         OP_SHR: begin
            wide    = {op_a, 1'b0} >> sh;
            alu_res = wide[WIDTH:1];
            if (sh != '0) c_new = wide[0];
         end
      endcase
   end

   assign alu_flag_upd = in_valid && flag_we && !flush && (alu_op != OP_PASS);

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid     <= 1'b0;
         ex_result    <= '0;
         ex_rdst      <= '0;
         ex_reg_write <= 1'b0;
         flags        <= '0;
      end else begin
         if (!stall) begin
            if (flag_src)
               flags <= flags_restore;
            else if (alu_flag_upd)
               flags <= {c_new, alu_res[WIDTH-1], (alu_res == '0)};
         end
         if (flush) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
         end else if (!stall) begin
            ex_valid     <= in_valid;
            ex_result    <= alu_res;
            ex_rdst      <= rdst_in;
            ex_reg_write <= reg_write_in & in_valid;
         end
      end
   end

endmodule

// File: tb/tb_execute_unit_p.sv
// Bench for execute_unit_p: directed vector table, randomized run against an
// arithmetic reference model, and a 32-bit instance for the parameter sweep.
module tb_execute_unit_p;

   localparam int W = 16;
   localparam logic [2:0] PASS = 3'd0, ADD = 3'd1, SUB = 3'd2, AND_ = 3'd3,
                          OR_ = 3'd4, NOT_ = 3'd5, SHL = 3'd6, SHR = 3'd7;

   typedef struct {
      logic        rst, vld, stall, flush, fwe, fsrc, ui, rw;
      logic [1:0]  fa, fb;
      logic [2:0]  op, frest, rdst;
      logic [15:0] d1, d2, imm, wb;
      logic        e_vld, e_rw, chk;
      logic [15:0] e_res;
      logic [2:0]  e_rdst, e_flags;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b0, in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
   logic [15:0] data1_val = '0, data2_val = '0, imm_val = '0, wb_data = '0;
   logic [1:0]  fwd_a = '0, fwd_b = '0;
   logic        use_imm = 1'b0, flag_we = 1'b0, flag_src = 1'b0, reg_write_in = 1'b0;
   logic [2:0]  alu_op = '0, flags_restore = '0, rdst_in = '0;
   logic        ex_valid, ex_reg_write;
   logic [15:0] ex_result;
   logic [2:0]  ex_rdst, flags;

   execute_unit_p #(.WIDTH(16), .RADDR_W(3)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
      .data1_val(data1_val), .data2_val(data2_val), .imm_val(imm_val),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .use_imm(use_imm), .alu_op(alu_op),
      .flag_we(flag_we), .flag_src(flag_src), .flags_restore(flags_restore),
      .rdst_in(rdst_in), .reg_write_in(reg_write_in), .wb_data(wb_data),
      .ex_valid(ex_valid), .ex_result(ex_result), .ex_rdst(ex_rdst),
      .ex_reg_write(ex_reg_write), .flags(flags));

   logic        w_rst = 1'b0, w_vld = 1'b0, w_stall = 1'b0, w_flush = 1'b0;
   logic [31:0] w_d1 = '0, w_d2 = '0, w_imm = '0, w_wb = '0;
   logic [1:0]  w_fa = '0, w_fb = '0;
   logic        w_ui = 1'b0, w_fwe = 1'b0, w_fsrc = 1'b0, w_rw = 1'b0;
   logic [2:0]  w_op = '0, w_frest = '0;
   logic [4:0]  w_rdst = '0;
   logic        w_ex_valid, w_ex_rw;
   logic [31:0] w_ex_result;
   logic [4:0]  w_ex_rdst;
   logic [2:0]  w_flags;

   execute_unit_p #(.WIDTH(32), .RADDR_W(5)) dut32 (
      .clk(clk), .rst(w_rst), .in_valid(w_vld), .stall(w_stall), .flush(w_flush),
      .data1_val(w_d1), .data2_val(w_d2), .imm_val(w_imm),
      .fwd_a(w_fa), .fwd_b(w_fb), .use_imm(w_ui), .alu_op(w_op),
      .flag_we(w_fwe), .flag_src(w_fsrc), .flags_restore(w_frest),
      .rdst_in(w_rdst), .reg_write_in(w_rw), .wb_data(w_wb),
      .ex_valid(w_ex_valid), .ex_result(w_ex_result), .ex_rdst(w_ex_rdst),
      .ex_reg_write(w_ex_rw), .flags(w_flags));

   int n_vec = 0, n_miss = 0;

   // reference model state (16-bit instance)
   logic        m_vld, m_rw, m_known;
   logic [15:0] m_res;
   logic [2:0]  m_rdst, m_flags;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] op, input logic [1:0] fa, input logic [1:0] fb,
                               input logic ui, input logic [15:0] d1, input logic [15:0] d2,
                               input logic [15:0] imm, input logic fwe, input logic [2:0] rdst);
      vec_t v;
      v = '{default: '0};
      v.op = op; v.fa = fa; v.fb = fb; v.ui = ui; v.d1 = d1; v.d2 = d2;
      v.imm = imm; v.fwe = fwe; v.rdst = rdst; v.vld = 1'b1; v.rw = 1'b1; v.chk = 1'b1;
      return v;
   endfunction

   function automatic vec_t ex(input vec_t vi, input logic e_vld, input logic [15:0] e_res,
                               input logic [2:0] e_rdst, input logic e_rw, input logic [2:0] e_flags);
      vec_t v;
      v = vi;
      v.e_vld = e_vld; v.e_res = e_res; v.e_rdst = e_rdst; v.e_rw = e_rw; v.e_flags = e_flags;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      rst = v.rst; in_valid = v.vld; stall = v.stall; flush = v.flush;
      data1_val = v.d1; data2_val = v.d2; imm_val = v.imm; wb_data = v.wb;
      fwd_a = v.fa; fwd_b = v.fb; use_imm = v.ui; alu_op = v.op;
      flag_we = v.fwe; flag_src = v.fsrc; flags_restore = v.frest;
      rdst_in = v.rdst; reg_write_in = v.rw;
   endtask

   task automatic model_step(input vec_t v);
      longint unsigned a, b, r, mask;
      bit c, n, z;
      int unsigned s;
      mask = (64'd1 << W) - 1;
      if (v.rst) begin
         m_vld = 0; m_rw = 0; m_res = '0; m_rdst = '0; m_flags = '0; m_known = 1;
         return;
      end
      case (v.fa)
         2'd0: a = v.d1;
         2'd1: a = m_res;
         2'd2: a = v.wb;
         default: a = v.d2;
      endcase
      if (v.ui) b = v.imm;
      else case (v.fb)
         2'd0: b = v.d2;
         2'd1: b = m_res;
         2'd2: b = v.wb;
         default: b = 1;
      endcase
      c = m_flags[2];
      s = int'(b % W);
      case (v.op)
         PASS: r = a;
         ADD: begin r = a + b; c = ((r >> W) & 1) != 0; end
         SUB: begin r = a - b; c = (a < b); end
         AND_: r = a & b;
         OR_: r = a | b;
         NOT_: r = ~a;
         SHL: begin r = a << s; if (s != 0) c = ((a >> (W - s)) & 1) != 0; end
         default: begin r = a >> s; if (s != 0) c = ((a >> (s - 1)) & 1) != 0; end
      endcase
      r = r & mask;
      z = (r == 0);
      n = ((r >> (W - 1)) & 1) != 0;
      if (!v.stall) begin
         if (v.fsrc) m_flags = v.frest;
         else if (v.vld && v.fwe && !v.flush && v.op != PASS) m_flags = {c, n, z};
      end
      if (v.flush) begin
         m_vld = 0; m_rw = 0; m_known = 0;
      end else if (!v.stall) begin
         m_vld = v.vld; m_res = r[15:0]; m_rdst = v.rdst; m_rw = v.rw & v.vld; m_known = 1;
      end
   endtask

   function automatic logic [15:0] rnd_val();
      case ($urandom_range(0, 5))
         0: return 16'h0000;
         1: return 16'hFFFF;
         2: return 16'h8000;
         3: return 16'h0001;
         default: return 16'($urandom);
      endcase
   endfunction

   vec_t tv[$];
   vec_t v;

   initial begin
      m_vld = 0; m_rw = 0; m_res = '0; m_rdst = '0; m_flags = '0; m_known = 0;

      v = mk(PASS, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0); v.rst = 1;
      tv.push_back(ex(v, 0, 16'h0000, 0, 0, 3'b000));
      tv.push_back(ex(mk(ADD, 0, 0, 0, 16'h7FFF, 16'h0001, 0, 1, 1), 1, 16'h8000, 1, 1, 3'b010));
      tv.push_back(ex(mk(ADD, 0, 0, 0, 16'h0003, 16'h0004, 0, 1, 2), 1, 16'h0007, 2, 1, 3'b000));
      tv.push_back(ex(mk(SUB, 1, 0, 1, 16'h0000, 16'h0000, 16'h0007, 1, 3), 1, 16'h0000, 3, 1, 3'b001));
      tv.push_back(ex(mk(SUB, 0, 0, 0, 16'h0001, 16'h0002, 0, 1, 4), 1, 16'hFFFF, 4, 1, 3'b110));
      tv.push_back(ex(mk(SHL, 0, 0, 1, 16'h8001, 0, 16'h0001, 1, 5), 1, 16'h0002, 5, 1, 3'b100));
      tv.push_back(ex(mk(SHR, 0, 0, 1, 16'h0003, 0, 16'h0001, 1, 6), 1, 16'h0001, 6, 1, 3'b100));
      tv.push_back(ex(mk(SHL, 0, 0, 1, 16'h1234, 0, 16'h0010, 1, 7), 1, 16'h1234, 7, 1, 3'b100));
      tv.push_back(ex(mk(ADD, 0, 0, 0, 16'hFFFF, 16'h0002, 0, 1, 1), 1, 16'h0001, 1, 1, 3'b100));
      for (int i = 0; i < 3; i++) begin
         v = mk(ADD, 0, 0, 0, 16'h0005, 16'h0005, 0, 1, 2); v.stall = 1;
         tv.push_back(ex(v, 1, 16'h0001, 1, 1, 3'b100));
      end
      v = mk(SUB, 0, 0, 0, 16'h0001, 16'h0002, 0, 1, 3); v.stall = 1; v.flush = 1;
      v = ex(v, 0, 16'h0, 0, 0, 3'b100); v.chk = 0; tv.push_back(v);
      v = mk(ADD, 0, 0, 0, 16'h0010, 16'h0020, 0, 1, 4); v.fsrc = 1; v.frest = 3'b101;
      tv.push_back(ex(v, 1, 16'h0030, 4, 1, 3'b101));
      v = mk(ADD, 0, 0, 0, 16'h0009, 16'h0020, 0, 1, 5); v.stall = 1; v.fsrc = 1; v.frest = 3'b010;
      tv.push_back(ex(v, 1, 16'h0030, 4, 1, 3'b101));
      v = mk(ADD, 0, 0, 0, 16'h0009, 16'h0020, 0, 1, 5); v.flush = 1; v.fsrc = 1; v.frest = 3'b011;
      v = ex(v, 0, 16'h0, 0, 0, 3'b011); v.chk = 0; tv.push_back(v);
      v = mk(ADD, 2, 3, 0, 16'h0, 16'h0, 0, 1, 5); v.wb = 16'h1111;
      tv.push_back(ex(v, 1, 16'h1112, 5, 1, 3'b000));
      tv.push_back(ex(mk(NOT_, 3, 0, 0, 16'h0000, 16'h00FF, 0, 1, 6), 1, 16'hFF00, 6, 1, 3'b010));
      v = mk(ADD, 0, 0, 0, 16'h0002, 16'h0003, 0, 1, 7); v.vld = 0;
      tv.push_back(ex(v, 0, 16'h0005, 7, 0, 3'b010));
      tv.push_back(ex(mk(PASS, 0, 0, 0, 16'h0000, 16'h1234, 0, 1, 1), 1, 16'h0000, 1, 1, 3'b010));
      v = mk(OR_, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 2); v.rw = 0;
      tv.push_back(ex(v, 1, 16'h0000, 2, 0, 3'b001));
      v = mk(SUB, 0, 0, 0, 16'h0001, 16'h0002, 0, 1, 3); v.flush = 1;
      v = ex(v, 0, 16'h0, 0, 0, 3'b001); v.chk = 0; tv.push_back(v);
      v = mk(ADD, 0, 0, 0, 16'h0001, 16'h0001, 0, 1, 3); v.rst = 1;
      tv.push_back(ex(v, 0, 16'h0000, 0, 0, 3'b000));
      tv.push_back(ex(mk(AND_, 0, 0, 0, 16'hF0F0, 16'hFF00, 0, 1, 3), 1, 16'hF000, 3, 1, 3'b010));
      tv.push_back(ex(mk(ADD, 1, 1, 0, 16'h0, 16'h0, 0, 1, 4), 1, 16'hE000, 4, 1, 3'b110));

      foreach (tv[i]) begin
         drive(tv[i]);
         @(posedge clk); #1;
         model_step(tv[i]);
         check($sformatf("t%0d valid", i), 32'(ex_valid), 32'(tv[i].e_vld));
         check($sformatf("t%0d reg_write", i), 32'(ex_reg_write), 32'(tv[i].e_rw));
         check($sformatf("t%0d flags", i), 32'(flags), 32'(tv[i].e_flags));
         if (tv[i].chk) begin
            check($sformatf("t%0d result", i), 32'(ex_result), 32'(tv[i].e_res));
            check($sformatf("t%0d rdst", i), 32'(ex_rdst), 32'(tv[i].e_rdst));
         end
      end

      for (int i = 0; i < 600; i++) begin
         v = '{default: '0};
         v.rst   = ($urandom_range(0, 49) == 0);
         v.vld   = ($urandom_range(0, 3) != 0);
         v.stall = ($urandom_range(0, 6) == 0);
         v.flush = ($urandom_range(0, 9) == 0);
         v.fsrc  = ($urandom_range(0, 9) == 0);
         v.fwe   = ($urandom_range(0, 3) != 0);
         v.ui    = ($urandom_range(0, 3) == 0);
         v.rw    = 1'($urandom);
         v.fa    = 2'($urandom);
         v.fb    = 2'($urandom);
         if (!m_known && v.fa == 2'd1) v.fa = 2'd0;
         if (!m_known && v.fb == 2'd1) v.fb = 2'd0;
         v.op    = 3'($urandom);
         v.frest = 3'($urandom);
         v.rdst  = 3'($urandom);
         v.d1 = rnd_val(); v.d2 = rnd_val(); v.wb = rnd_val();
         v.imm = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 17)) : rnd_val();
         drive(v);
         @(posedge clk); #1;
         model_step(v);
         check($sformatf("r%0d valid", i), 32'(ex_valid), 32'(m_vld));
         check($sformatf("r%0d reg_write", i), 32'(ex_reg_write), 32'(m_rw));
         check($sformatf("r%0d flags", i), 32'(flags), 32'(m_flags));
         if (m_known) begin
            check($sformatf("r%0d result", i), 32'(ex_result), 32'(m_res));
            check($sformatf("r%0d rdst", i), 32'(ex_rdst), 32'(m_rdst));
         end
      end

      // 32-bit instance
      w_rst = 1;
      @(posedge clk); #1;
      check("w32 reset valid", 32'(w_ex_valid), 32'd0);
      check("w32 reset flags", 32'(w_flags), 32'd0);
      w_rst = 0; w_vld = 1; w_op = ADD; w_d1 = 32'hFFFF_FFFF; w_d2 = 32'h1;
      w_fwe = 1; w_rw = 1; w_rdst = 5'd31;
      @(posedge clk); #1;
      check("w32 add result", w_ex_result, 32'h0);
      check("w32 add flags", 32'(w_flags), 32'b101);
      check("w32 add valid", 32'(w_ex_valid), 32'd1);
      check("w32 add rdst", 32'(w_ex_rdst), 32'd31);
      check("w32 add rw", 32'(w_ex_rw), 32'd1);
      w_op = SHL; w_d1 = 32'h0000_0003; w_ui = 1; w_imm = 32'd31; w_rdst = 5'd7;
      @(posedge clk); #1;
      check("w32 shl result", w_ex_result, 32'h8000_0000);
      check("w32 shl flags", 32'(w_flags), 32'b110);
      w_rst = 1; w_op = ADD; w_ui = 0; w_d1 = 32'h5; w_d2 = 32'h6;
      @(posedge clk); #1;
      check("w32 midrst valid", 32'(w_ex_valid), 32'd0);
      check("w32 midrst result", w_ex_result, 32'h0);
      check("w32 midrst rdst", 32'(w_ex_rdst), 32'd0);
      check("w32 midrst rw", 32'(w_ex_rw), 32'd0);
      check("w32 midrst flags", 32'(w_flags), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
